// File: rtl/aes_result_checker.sv
// aes_result_checker: latency-matched compare of AES enc/dec outputs.
// Optional first-failure capture: define AES_CHECKER_CAPTURE_EN.
package aes_pkg;
  typedef logic [127:0] state_t;
  typedef logic [127:0] key_t;
  typedef struct packed {
    state_t plain;
    state_t encrypt;
    key_t   key;
  } vec_t;
endpackage

module aes_result_checker
  import aes_pkg::*;
#(
  parameter int LATENCY = 10,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [127:0]     in_plain,
  input  logic [127:0]     in_encrypt,
  input  logic [127:0]     in_key,
  input  logic [127:0]     dut_encrypt,
  input  logic [127:0]     dut_plain,
  output logic             chk_valid,
  output logic             enc_mismatch,
  output logic             dec_mismatch,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             idle,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [127:0]     first_fail_key,
  output logic [127:0]     first_fail_plain
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LATENCY:0] vld;
  vec_t             line  [LATENCY+1];
  logic [CNT_W-1:0] idx_q [LATENCY+1];
  logic [CNT_W-1:0] vec_idx;

  logic enc_bad;
  logic dec_bad;
  logic cmp_fail;
  logic do_cmp;

  assign enc_bad  = dut_encrypt != line[LATENCY].encrypt;
  assign dec_bad  = dut_plain != line[LATENCY].plain;
  assign cmp_fail = enc_bad | dec_bad;
  assign do_cmp   = vld[LATENCY] & ~clear;
  assign idle     = ~|vld;

  // Valid bits shift every cycle; clear drops everything in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld <= '0;
    end else if (clear) begin
      vld <= '0;
    end else if (LATENCY == 1) begin
      vld <= {vld[0], in_valid};
    end else begin
      vld <= {vld[LATENCY-1:0], in_valid};
    end
  end

  // Payload shifts alongside the valid bits; no reset needed.
  always_ff @(posedge clock) begin
    line[0] <= '{
      plain:   in_plain,
      encrypt: in_encrypt,
      key:     in_key
    };
    idx_q[0] <= vec_idx;
    for (int k = 1; k <= LATENCY; k++) begin
      line[k]  <= line[k-1];
      idx_q[k] <= idx_q[k-1];
    end
  end

  // Running index of accepted vectors, wraps naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vec_idx <= '0;
    end else if (clear) begin
      vec_idx <= '0;
    end else if (in_valid) begin
      vec_idx <= vec_idx + 1'b1;
    end
  end

  // Per-compare status pulse; flags are zero outside the pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chk_valid    <= 1'b0;
      enc_mismatch <= 1'b0;
      dec_mismatch <= 1'b0;
    end else begin
      chk_valid    <= do_cmp;
      enc_mismatch <= do_cmp & enc_bad;
      dec_mismatch <= do_cmp & dec_bad;
    end
  end

  // Saturating pass/fail tallies.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (clear) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (do_cmp) begin
      if (!cmp_fail) begin
        if (pass_count != CNT_MAX) begin
          pass_count <= pass_count + 1'b1;
        end
      end else if (fail_count != CNT_MAX) begin
        fail_count <= fail_count + 1'b1;
      end
    end
  end

`ifdef AES_CHECKER_CAPTURE_EN
  typedef enum logic {
    EMPTY,
    CAPTURED
  } cap_state_t;

  cap_state_t cap_state;
  cap_state_t cap_next;
  logic       cap_load;

  // Capture state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_state <= EMPTY;
    end else begin
      cap_state <= cap_next;
    end
  end

  // Arm on reset/clear, latch once on the first failing compare.
  always_comb begin
    cap_next = cap_state;
    cap_load = 1'b0;
    unique case (cap_state)
      EMPTY: begin
        if (do_cmp && cmp_fail) begin
          cap_load = 1'b1;
          cap_next = CAPTURED;
        end
      end
      CAPTURED: begin
        if (clear) begin
          cap_next = EMPTY;
        end
      end
    endcase
  end

  // First-failure snapshot registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_fail_idx   <= '0;
      first_fail_key   <= '0;
      first_fail_plain <= '0;
    end else if (clear) begin
      first_fail_idx   <= '0;
      first_fail_key   <= '0;
      first_fail_plain <= '0;
    end else if (cap_load) begin
      first_fail_idx   <= idx_q[LATENCY];
      first_fail_key   <= line[LATENCY].key;
      first_fail_plain <= line[LATENCY].plain;
    end
  end
`else
  logic unused_cap;
  assign unused_cap = ^{idx_q[LATENCY],
                        line[LATENCY].key};

  assign first_fail_idx   = '0;
  assign first_fail_key   = '0;
  assign first_fail_plain = '0;
`endif

endmodule

// File: tb/tb_aes_result_checker.sv
// tb_aes_result_checker: random vectors vs cycle-keyed scoreboard.
// Capture expectations follow AES_CHECKER_CAPTURE_EN.
module tb_aes_result_checker;
  localparam int L = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_plain = '0;
  logic [127:0] in_encrypt = '0;
  logic [127:0] in_key = '0;
  logic [127:0] dut_encrypt = '0;
  logic [127:0] dut_plain = '0;

  logic         chk_valid, enc_mismatch, dec_mismatch, idle;
  logic [15:0]  pass_count, fail_count, first_fail_idx;
  logic [127:0] first_fail_key, first_fail_plain;

  logic         chk4, enc4, dec4, idle4;
  logic [3:0]   pass4, fail4, ffidx4;
  logic [127:0] ffkey4, ffpl4;

  aes_result_checker #(.LATENCY(L), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_plain(in_plain),
    .in_encrypt(in_encrypt), .in_key(in_key),
    .dut_encrypt(dut_encrypt), .dut_plain(dut_plain),
    .chk_valid(chk_valid), .enc_mismatch(enc_mismatch),
    .dec_mismatch(dec_mismatch), .pass_count(pass_count),
    .fail_count(fail_count), .idle(idle),
    .first_fail_idx(first_fail_idx),
    .first_fail_key(first_fail_key),
    .first_fail_plain(first_fail_plain)
  );

  aes_result_checker #(.LATENCY(L), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_plain(in_plain),
    .in_encrypt(in_encrypt), .in_key(in_key),
    .dut_encrypt(dut_encrypt), .dut_plain(dut_plain),
    .chk_valid(chk4), .enc_mismatch(enc4),
    .dec_mismatch(dec4), .pass_count(pass4),
    .fail_count(fail4), .idle(idle4),
    .first_fail_idx(ffidx4),
    .first_fail_key(ffkey4),
    .first_fail_plain(ffpl4)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit           bad_e;
    bit           bad_d;
    int           idx;
    logic [127:0] key;
    logic [127:0] plain;
  } exp_t;

  exp_t         exp_q [int];
  logic [127:0] drv_enc [int];
  logic [127:0] drv_pl [int];

  int           vidx, exp_pass, exp_fail;
  int           pulses = 0;
  int           pulses4 = 0;
  bit           have_ff;
  int           ff_idx;
  logic [127:0] ff_key, ff_plain;
  exp_t         e;

  function automatic int sat(int v, int w);
    int m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard: exp_q holds what chk_valid must show after each edge.
  always @(negedge clock) begin
    if (exp_q.exists(cyc)) begin
      e = exp_q[cyc];
      exp_q.delete(cyc);
      if (e.bad_e || e.bad_d) begin
        exp_fail++;
        if (!have_ff) begin
          have_ff  = 1;
          ff_idx   = e.idx;
          ff_key   = e.key;
          ff_plain = e.plain;
        end
      end else begin
        exp_pass++;
      end
      check("chk_valid", chk_valid, 1);
      check("enc_mm", enc_mismatch, e.bad_e);
      check("dec_mm", dec_mismatch, e.bad_d);
      check("pass_cnt", pass_count, sat(exp_pass, 16));
      check("fail_cnt", fail_count, sat(exp_fail, 16));
    end else if (chk_valid) begin
      check("spurious_chk", chk_valid, 0);
    end
    if (chk_valid) pulses++;
    if (chk4) pulses4++;
  end

  task automatic zero_model();
    exp_pass = 0;
    exp_fail = 0;
    have_ff  = 0;
    ff_idx   = 0;
    ff_key   = '0;
    ff_plain = '0;
    vidx     = 0;
  endtask

  task automatic purge(int from);
    int ks[$];
    foreach (exp_q[k]) if (k >= from) ks.push_back(k);
    foreach (ks[i]) exp_q.delete(ks[i]);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    in_valid = 0;
    clear    = 0;
    if (drv_enc.exists(cyc)) begin
      dut_encrypt = drv_enc[cyc];
      dut_plain   = drv_pl[cyc];
      drv_enc.delete(cyc);
      drv_pl.delete(cyc);
    end else begin
      dut_encrypt = rnd128();
      dut_plain   = rnd128();
    end
  endtask

  task automatic apply(bit be, bit bd);
    int s;
    in_plain   = rnd128();
    in_encrypt = rnd128();
    in_key     = rnd128();
    in_valid   = 1;
    s = cyc + 1;
    drv_enc[s+L] = in_encrypt ^ 128'(be);
    drv_pl[s+L]  = in_plain ^ 128'(bd);
    exp_q[s+L+1] = '{be, bd, vidx % 65536, in_key, in_plain};
    vidx++;
    tick();
  endtask

  task automatic do_clear();
    clear = 1;
    purge(cyc + 1);
    tick();
    zero_model();
  endtask

  task automatic drain();
    repeat (L + 3) tick();
  endtask

  task automatic ff_check(string tag);
    logic [127:0] xi, xk, xp;
`ifdef AES_CHECKER_CAPTURE_EN
    xi = 128'(ff_idx);
    xk = ff_key;
    xp = ff_plain;
`else
    xi = '0;
    xk = '0;
    xp = '0;
`endif
    check({tag, "_ff_idx"}, first_fail_idx, xi);
    check({tag, "_ff_key"}, first_fail_key, xk);
    check({tag, "_ff_plain"}, first_fail_plain, xp);
  endtask

  int p0, q0;

  initial begin
    zero_model();
    #2;
    check("rst_chk", chk_valid, 0);
    check("rst_pass", pass_count, 0);
    check("rst_fail", fail_count, 0);
    check("rst_idle", idle, 1);
    ff_check("rst");
    tick();
    tick();
    reset = 1;
    tick();

    p0 = pulses;
    for (int i = 0; i < 20; i++) begin
      apply(0, 0);
      if (i == 0) check("busy_idle", idle, 0);
    end
    drain();
    check("t1_pass", pass_count, 20);
    check("t1_fail", fail_count, 0);
    check("t1_pulses", pulses - p0, 20);
    check("t1_idle", idle, 1);

    do_clear();
    for (int i = 0; i < 8; i++) apply(i == 5, 0);
    drain();
    check("t2_pass", pass_count, 7);
    check("t2_fail", fail_count, 1);
    ff_check("t2");

    do_clear();
    for (int i = 0; i < 8; i++) apply(i == 6, i == 3 || i == 6);
    drain();
    check("t3_fail", fail_count, 2);
    check("t3_pass", pass_count, 6);
    ff_check("t3");

    do_clear();
    q0 = pulses4;
    for (int i = 0; i < 20; i++) apply(0, 0);
    drain();
    check("sat_pass4", pass4, 15);
    check("sat_fail4", fail4, 0);
    check("sat_pulses4", pulses4 - q0, 20);
    check("sat_pass16", pass_count, 20);

    for (int i = 0; i < 4; i++) apply(0, 0);
    reset = 0;
    #1;
    purge(cyc);
    zero_model();
    check("arst_chk", chk_valid, 0);
    check("arst_pass", pass_count, 0);
    check("arst_pass4", pass4, 0);
    check("arst_fail", fail_count, 0);
    check("arst_idle", idle, 1);
    ff_check("arst");
    tick();
    tick();
    reset = 1;
    tick();
    apply(0, 0);
    apply(0, 0);
    drain();
    check("arst_after", pass_count, 2);

    apply(1, 0);
    repeat (L) tick();
    p0 = pulses;
    in_plain   = rnd128();
    in_encrypt = rnd128();
    in_valid   = 1;
    do_clear();
    drain();
    check("clr_pulses", pulses - p0, 0);
    check("clr_pass", pass_count, 0);
    check("clr_fail", fail_count, 0);
    check("clr_idle", idle, 1);
    ff_check("clr");
    apply(0, 0);
    drain();
    check("clr_after", pass_count, 1);
    check("pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_result_checker.md
# aes_result_checker

Self-checking stage that sits directly downstream of the AES encoder/decoder pair in the HDL-side testbench. It receives each test vector when it is applied to the DUTs and holds the expected ciphertext and plaintext in a latency-matched delay line. When the DUT outputs emerge, it compares them against the expected values and keeps saturating pass/fail counts. Per-check outcomes are visible in hardware, so no per-cycle output traffic back to the HVL side is needed.

## Interface
Parameters:
- LATENCY, 10: DUT pipeline latency in clock edges, identical for encoder and decoder; legal range 1..64.
- CNT_W, 16: width of the pass/fail counters and vector index.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of delay line, counters, status.
- in_valid  in  1  a vector is being applied to the DUT inputs this edge.
- in_plain  in  state_t (128)  plaintext applied to encoder = expected decoder output.
- in_encrypt  in  state_t (128)  ciphertext applied to decoder = expected encoder output.
- in_key  in  key_t  key applied to both DUTs.
- dut_encrypt  in  state_t  encoder output.
- dut_plain  in  state_t  decoder output.
- chk_valid  out  1  a comparison completed; registered, one-cycle pulse.
- enc_mismatch  out  1  qualified by chk_valid: dut_encrypt differed.
- dec_mismatch  out  1  qualified by chk_valid: dut_plain differed.
- pass_count  out  CNT_W  vectors with both outputs matching.
- fail_count  out  CNT_W  vectors with at least one mismatch.
- idle  out  1  no valid entry in the delay line.
- first_fail_idx  out  CNT_W  index of the first failing vector (capture feature).
- first_fail_key  out  key_t  key of the first failing vector (capture feature).
- first_fail_plain  out  state_t  plaintext of the first failing vector (capture feature).

## Operation
- Delay line: LATENCY+1 stages (0..LATENCY), each holding {valid, plain, encrypt, key, idx}. It shifts every cycle; there is no stall.
- Stage 0 loads {in_valid, in_plain, in_encrypt, in_key, vec_idx}.
- vec_idx: internal CNT_W counter, increments on each accepted in_valid, wraps modulo 2^CNT_W.
- Compare: when stage LATENCY is valid, compare it against dut_encrypt/dut_plain.
  - Both equal: pass_count+1.
  - Otherwise: fail_count+1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- Status registers:
  - chk_valid is high for exactly one cycle per valid compare.
  - enc_mismatch/dec_mismatch reflect that compare and hold 0 when chk_valid is 0.
- idle = no valid bit set in stages 0..LATENCY.
- States per stage are implicit (valid bit). No other FSM exists except capture state EMPTY→CAPTURED; CAPTURED is left only by clear or reset.

## Timing
- Vector sampled at edge E0 occupies stage k after edge E_k.
- The DUT result must be stable on dut_* after E_LATENCY. It is sampled at E_LATENCY+1.
- chk_valid, mismatch flags and counter updates are visible after E_LATENCY+1.
- Back-to-back in_valid every cycle is supported at full throughput, one compare per cycle.
- Reset (async assert, any time): all valid bits, vec_idx, counters, status and capture registers go to 0 immediately. Data fields need not be reset. In-flight vectors are discarded and not counted.
- Reset deassertion is synchronised by the caller. The first sampled edge after release may accept in_valid.
- clear coincident with in_valid or a compare: clear wins. The vector is dropped and the compare is not counted. All outputs read 0 after the edge.
- Saturation: a compare at a saturated counter leaves it unchanged. chk_valid/mismatch still pulse.

## Configuration
- AES_CHECKER_CAPTURE_EN defined: on the first failing compare after reset/clear, latch idx, key and plain of stage LATENCY into the first_fail_* outputs. Later failures leave them unchanged.
- AES_CHECKER_CAPTURE_EN undefined: first_fail_* ports remain and are tied to 0. No capture registers are built.

## Test plan
- Reset, then 20 vectors with matching DUT model → pass_count=20, fail_count=0, 20 chk_valid pulses, each LATENCY+1 edges after its input. idle=1 afterwards.
- Vector 5 of 8 with dut_encrypt bit 0 flipped → fail_count=1, pass_count=7, enc_mismatch=1 / dec_mismatch=0 on that pulse. With macro: first_fail_idx=5, first_fail_key matches vector 5.
- Vectors 3 (decoder error) and 6 (both errors) → fail_count=2. Captured idx stays 3 with macro, 0 without.
- CNT_W=4, 20 passing vectors → pass_count holds at 15. chk_valid still pulses 20 times.
- Async reset asserted mid-stream with 4 vectors in flight → all outputs 0 at once. After release, 2 new vectors → pass_count=2.
- clear coincident with in_valid and a pending compare → counters 0, that compare not counted, new vector dropped (no chk_valid for it).
